id_run_tracker: RTL and testbench
=================================

ID_RUN_TRACKER -- requirements
Module: id_run_tracker

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of entries in the run-length FIFO (power of two).
REQ-002 SHALL have parameter LW, default 8, width of run-length values.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port match  input  1  recogniser output; high while the current char run is letters followed by one or more digits.
REQ-006 SHALL have port len_ready  input  1  consumer pops the FIFO head when high and len_valid is high.
REQ-007 SHALL have port len_valid  output  1  FIFO non-empty.
REQ-008 SHALL have port len_data  output  LW  FIFO head value, valid when len_valid is high.
REQ-009 SHALL have port token_cnt  output  16  completed matching runs since reset.
REQ-010 SHALL have port cur_len  output  LW  cycles match has been high in the current run.
REQ-011 SHALL have port max_len  output  LW  longest completed run since reset.
REQ-012 SHALL have port overflow  output  1  sticky; a completed run was dropped because the FIFO was full.

Function
REQ-013 SHALL implement FSM states IDLE and RUN; IDLE->RUN when match=1, RUN->IDLE when match=0, otherwise hold.
REQ-014 SHALL load cur_len=1 on the IDLE->RUN edge, increment it each further cycle with match=1 in RUN, and saturate at 2^LW-1.
REQ-015 SHALL, on the RUN->IDLE edge (run completion), clear cur_len to 0 in the same edge.
REQ-016 SHALL, on run completion, increment token_cnt by 1, saturating at 65535.
REQ-017 SHALL, on run completion, set max_len to the completed length when that length exceeds max_len.
REQ-018 SHALL, on run completion, push the completed length into the FIFO when it is not full, or when it is full and a pop occurs in the same cycle.
REQ-019 SHALL, on run completion with the FIFO full and no same-cycle pop, drop the value and set overflow to 1 until reset.
REQ-020 SHALL pop the head on a posedge where len_valid=1 and len_ready=1; len_ready with an empty FIFO SHALL be ignored.
REQ-021 SHALL, on a push into an empty FIFO, assert len_valid the next cycle; there is no same-cycle bypass to len_data.
REQ-022 SHALL preserve FIFO order and wrap read/write pointers modulo DEPTH, using a DEPTH+1-state occupancy count for full/empty.
REQ-023 SHALL drive all outputs from registers only.

Reset
REQ-024 SHALL, while reset=1 at posedge, set state=IDLE, cur_len=0, token_cnt=0, max_len=0, overflow=0, and empty the FIFO (len_valid=0, len_data=0).
REQ-025 SHALL, on reset during RUN, discard the in-progress run with no push and no count.
REQ-026 SHALL give reset priority over match and len_ready in the same cycle.

Structure
REQ-027 SHALL place state encodings (IDLE=1'b0, RUN=1'b1), default DEPTH, LW, and the 16-bit count width in a shared header/package id_defs.
REQ-028 SHALL implement the FIFO as one sub-module, len_fifo (parameters DEPTH, LW; push/pop/full/empty/head ports); the FSM, counters and max tracking SHALL stay in id_run_tracker.

Verification
REQ-029 SHALL cover: match high 3 cycles then low -> cur_len 1,2,3 then 0; token_cnt=1; len_valid next cycle with len_data=3; max_len=3.
REQ-030 SHALL cover: 5 runs of lengths 2,4,1,6,3 with len_ready=0 -> first four queued, run of length 3 dropped, overflow=1, token_cnt=5, max_len=6; then drain -> 2,4,1,6 in order.
REQ-031 SHALL cover: FIFO full and run completion in the same cycle as a pop -> pop and push both occur, occupancy stays 4, overflow stays 0.
REQ-032 SHALL cover: match held high 300 cycles -> cur_len saturates at 255; on completion pushed value=255, max_len=255.
REQ-033 SHALL cover: reset asserted at cycle 2 of a run with 2 entries queued -> next cycle all outputs 0, len_valid=0, no count for the aborted run.
REQ-034 SHALL cover: len_ready held high with an empty FIFO, then one run of length 1 -> len_valid high one cycle with len_data=1, then low; no spurious pops.

Source files
------------

// File: rtl/id_defs.sv
// Shared definitions for the identifier run tracker.
// State encodings, default sizes and the token count width.
package id_defs;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_DEPTH = 4;
    localparam int DEF_LW    = 8;
    localparam int CNT_W     = 16;

endpackage

// File: rtl/len_fifo.sv
// Small run-length FIFO with registered head, valid and full flags.
// Pointers wrap modulo DEPTH; occupancy count decides full/empty.
module len_fifo #(
    parameter int DEPTH = 4,
    parameter int LW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [LW-1:0] din,
    output logic          full,
    output logic          empty,
    output logic          valid,
    output logic [LW-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [LW-1:0] mem_q [DEPTH];
    logic [LW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] head_q, head_d;
    logic          full_q, full_d;
    logic          valid_q, valid_d;
    logic          pop_ok, push_ok;

    // Next pointers, storage and registered head view
    always_comb begin
        pop_ok  = pop && valid_q;
        push_ok = push && (!full_q || pop_ok);
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (push_ok) begin
            mem_d[wr_q] = din;
            wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            cnt_d = cnt_q - 1'b1;
        end
        valid_d = (cnt_d != '0);
        full_d  = (cnt_d == CW'(DEPTH));
        head_d  = valid_d ? mem_d[rd_d] : '0;
    end

    // FIFO state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            head_q  <= '0;
            full_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            full_q  <= full_d;
            valid_q <= valid_d;
        end
    end

    assign full  = full_q;
    assign empty = !valid_q;
    assign valid = valid_q;
    assign head  = head_q;

endmodule

// File: rtl/id_run_tracker.sv
// Tracks runs of the identifier recogniser's match signal.
// Counts and measures completed runs and queues their lengths.
module id_run_tracker
    import id_defs::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int LW    = DEF_LW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             match,
    input  logic             len_ready,
    output logic             len_valid,
    output logic [LW-1:0]    len_data,
    output logic [CNT_W-1:0] token_cnt,
    output logic [LW-1:0]    cur_len,
    output logic [LW-1:0]    max_len,
    output logic             overflow
);

    state_t           state_q, state_d;
    logic [LW-1:0]    cur_len_q, cur_len_d;
    logic [LW-1:0]    max_len_q, max_len_d;
    logic [CNT_W-1:0] token_cnt_q, token_cnt_d;
    logic             overflow_q, overflow_d;
    logic             done, pop_ok, push;
    logic             fifo_full, fifo_empty, fifo_valid;
    logic [LW-1:0]    fifo_head;

    // Run FSM, length counter, statistics and push decision
    always_comb begin
        state_d     = state_q;
        cur_len_d   = cur_len_q;
        max_len_d   = max_len_q;
        token_cnt_d = token_cnt_q;
        overflow_d  = overflow_q;
        done        = 1'b0;
        pop_ok      = len_ready && fifo_valid;
        push        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (match) begin
                    state_d   = RUN;
                    cur_len_d = LW'(1);
                end
            end
            RUN: begin
                if (match) begin
                    if (cur_len_q != '1) begin
                        cur_len_d = cur_len_q + 1'b1;
                    end
                end else begin
                    state_d   = IDLE;
                    cur_len_d = '0;
                    done      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (done) begin
            if (token_cnt_q != '1) begin
                token_cnt_d = token_cnt_q + 1'b1;
            end
            if (cur_len_q > max_len_q) begin
                max_len_d = cur_len_q;
            end
            if (!fifo_full || pop_ok) begin
                push = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    // Tracker registers; reset discards any run in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_len_q   <= '0;
            max_len_q   <= '0;
            token_cnt_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_len_q   <= cur_len_d;
            max_len_q   <= max_len_d;
            token_cnt_q <= token_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    len_fifo #(
        .DEPTH(DEPTH),
        .LW   (LW)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop_ok),
        .din  (cur_len_q),
        .full (fifo_full),
        .empty(fifo_empty),
        .valid(fifo_valid),
        .head (fifo_head)
    );

    assign len_valid = fifo_valid;
    assign len_data  = fifo_head;
    assign token_cnt = token_cnt_q;
    assign cur_len   = cur_len_q;
    assign max_len   = max_len_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_id_run_tracker.sv
// Bench for id_run_tracker: directed runs, queued expected lengths,
// popped entries checked by an independent monitor.
module tb_id_run_tracker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        match = 1'b0;
    logic        len_ready = 1'b0;
    logic        len_valid;
    logic [7:0]  len_data;
    logic [15:0] token_cnt;
    logic [7:0]  cur_len;
    logic [7:0]  max_len;
    logic        overflow;

    int total = 0;
    int bad = 0;
    int exp_q[$];

    id_run_tracker #(.DEPTH(4), .LW(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .match    (match),
        .len_ready(len_ready),
        .len_valid(len_valid),
        .len_data (len_data),
        .token_cnt(token_cnt),
        .cur_len  (cur_len),
        .max_len  (max_len),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, int act, int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    // Monitor: any accepted head must match the oldest expected length
    always @(negedge clk) begin
        if (!reset && len_valid && len_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", int'(len_data), -1);
            end else begin
                chk("pop_data", int'(len_data), exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        match = 1'b0;
        len_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Run of n matching cycles followed by the completion cycle
    task automatic run_len(int n, bit queued);
        match = 1'b1;
        repeat (n) step();
        if (queued) exp_q.push_back(n > 255 ? 255 : n);
        match = 1'b0;
        step();
    endtask

    task automatic drain();
        len_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!len_valid) break;
        end
        len_ready = 1'b0;
        chk("drain_valid", int'(len_valid), 0);
        chk("drain_queue", exp_q.size(), 0);
    endtask

    initial begin
        step();
        do_reset();
        chk("rst_valid", int'(len_valid), 0);
        chk("rst_data", int'(len_data), 0);
        chk("rst_tok", int'(token_cnt), 0);
        chk("rst_cur", int'(cur_len), 0);
        chk("rst_max", int'(max_len), 0);
        chk("rst_ovf", int'(overflow), 0);

        // single run of 3
        match = 1'b1;
        step();
        chk("r3_cur1", int'(cur_len), 1);
        step();
        chk("r3_cur2", int'(cur_len), 2);
        step();
        chk("r3_cur3", int'(cur_len), 3);
        chk("r3_novalid", int'(len_valid), 0);
        exp_q.push_back(3);
        match = 1'b0;
        step();
        chk("r3_cur0", int'(cur_len), 0);
        chk("r3_tok", int'(token_cnt), 1);
        chk("r3_max", int'(max_len), 3);
        chk("r3_valid", int'(len_valid), 1);
        chk("r3_data", int'(len_data), 3);
        drain();

        // five runs, fifth dropped
        do_reset();
        run_len(2, 1);
        run_len(4, 1);
        run_len(1, 1);
        run_len(6, 1);
        chk("ov_pre", int'(overflow), 0);
        run_len(3, 0);
        chk("ov_flag", int'(overflow), 1);
        chk("ov_tok", int'(token_cnt), 5);
        chk("ov_max", int'(max_len), 6);
        chk("ov_head", int'(len_data), 2);
        drain();
        chk("ov_sticky", int'(overflow), 1);

        // full FIFO, completion coincides with a pop
        do_reset();
        run_len(1, 1);
        run_len(2, 1);
        run_len(3, 1);
        run_len(4, 1);
        match = 1'b1;
        repeat (5) step();
        exp_q.push_back(5);
        match = 1'b0;
        len_ready = 1'b1;
        step();
        len_ready = 1'b0;
        chk("fp_ovf", int'(overflow), 0);
        chk("fp_head", int'(len_data), 2);
        chk("fp_tok", int'(token_cnt), 5);
        drain();

        // saturation
        do_reset();
        match = 1'b1;
        repeat (300) step();
        chk("sat_cur", int'(cur_len), 255);
        run_len(0, 1);
        exp_q.pop_back();
        exp_q.push_back(255);
        chk("sat_max", int'(max_len), 255);
        chk("sat_data", int'(len_data), 255);
        chk("sat_tok", int'(token_cnt), 1);
        drain();

        // reset mid-run with entries queued
        do_reset();
        run_len(1, 1);
        run_len(2, 1);
        match = 1'b1;
        step();
        step();
        chk("ar_cur2", int'(cur_len), 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        match = 1'b0;
        exp_q.delete();
        chk("ar_valid", int'(len_valid), 0);
        chk("ar_data", int'(len_data), 0);
        chk("ar_tok", int'(token_cnt), 0);
        chk("ar_cur", int'(cur_len), 0);
        chk("ar_max", int'(max_len), 0);
        step();
        chk("ar_tok2", int'(token_cnt), 0);
        chk("ar_valid2", int'(len_valid), 0);

        // ready held with empty FIFO, then a run of 1
        len_ready = 1'b1;
        repeat (3) step();
        chk("er_valid", int'(len_valid), 0);
        match = 1'b1;
        step();
        exp_q.push_back(1);
        match = 1'b0;
        step();
        chk("er_valid1", int'(len_valid), 1);
        chk("er_data1", int'(len_data), 1);
        step();
        chk("er_valid0", int'(len_valid), 0);
        chk("er_queue", exp_q.size(), 0);
        len_ready = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
